// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI-to-RAM bridge.
// Optional build macro used by the bridge: AXI_RAM_BRIDGE_SKID_EN.
package axi_ram_pkg;

   // Bytes carried by every AXI beat; RAM words are this wide
   localparam int BEAT_BYTES = 4;

   // AXI burst encodings; the unused encoding 3 is handled as INCR
   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_e;

   // Top-level bridge sequencing
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      WRESP = 2'd3
   } bridge_state_e;

   // WRAP is only legal for 2, 4, 8 or 16 beats
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_ram_bridge_if.sv
// AXI4 slave-side bundle for the RAM bridge: shared AR/AW, W, B and R channels.
interface axi_ram_bridge_if #(
   parameter int ADDR_BITS = 14,
   parameter int ID_BITS   = 1
) ();

   logic                 arw_valid;
   logic                 arw_ready;
   logic [ADDR_BITS-1:0] arw_payload_addr;
   logic [ID_BITS-1:0]   arw_payload_id;
   logic [7:0]           arw_payload_len;
   logic [2:0]           arw_payload_size;
   logic [1:0]           arw_payload_burst;
   logic                 arw_payload_write;

   logic                 w_valid;
   logic                 w_ready;
   logic [31:0]          w_payload_data;
   logic [3:0]           w_payload_strb;
   logic                 w_payload_last;

   logic                 b_valid;
   logic                 b_ready;
   logic [ID_BITS-1:0]   b_payload_id;

   logic                 r_valid;
   logic                 r_ready;
   logic [31:0]          r_payload_data;
   logic [ID_BITS-1:0]   r_payload_id;
   logic                 r_payload_last;

   modport master (
      output arw_valid, arw_payload_addr, arw_payload_id, arw_payload_len,
             arw_payload_size, arw_payload_burst, arw_payload_write,
      input  arw_ready,
      output w_valid, w_payload_data, w_payload_strb, w_payload_last,
      input  w_ready,
      input  b_valid, b_payload_id,
      output b_ready,
      input  r_valid, r_payload_data, r_payload_id, r_payload_last,
      output r_ready
   );

   modport slave (
      input  arw_valid, arw_payload_addr, arw_payload_id, arw_payload_len,
             arw_payload_size, arw_payload_burst, arw_payload_write,
      output arw_ready,
      input  w_valid, w_payload_data, w_payload_strb, w_payload_last,
      output w_ready,
      output b_valid, b_payload_id,
      input  b_ready,
      output r_valid, r_payload_data, r_payload_id, r_payload_last,
      input  r_ready
   );

endinterface

// File: rtl/axi_ram_addr_gen.sv
// Next RAM word address for FIXED / INCR / WRAP bursts.
module axi_ram_addr_gen
   import axi_ram_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic [AW-1:0] addr,
   input  logic [7:0]    len,
   input  logic [1:0]    burst,
   output logic [AW-1:0] next_addr
);

   logic [AW-1:0] wrap_mask;
   logic [AW-1:0] addr_inc;

   // FIXED holds, WRAP rolls only the low log2(len+1) bits, everything else counts up
   always_comb begin
      wrap_mask      = '0;
      wrap_mask[3:0] = len[3:0];
      addr_inc       = addr + AW'(1);
      next_addr      = addr_inc;
      if (burst == FIXED) begin
         next_addr = addr;
      end else if (burst == WRAP && wrap_len_ok(len)) begin
         next_addr = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
      end
   end

endmodule

// File: rtl/axi_ram_bridge.sv
// AXI4 slave front-end for the single-port 32-bit on-chip RAM.
// Expands bursts into per-word RAM accesses and always answers OKAY.
// Build option AXI_RAM_BRIDGE_SKID_EN: adds a 2-entry registered R buffer so
// that ram_en no longer depends combinationally on r_ready.
module axi_ram_bridge
   import axi_ram_pkg::*;
#(
   parameter int ADDR_BITS = 14,
   parameter int ID_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   axi_ram_bridge_if.slave      axi,
   output logic                 ram_en,
   output logic                 ram_wr,
   output logic [ADDR_BITS-3:0] ram_addr,
   output logic [3:0]           ram_mask,
   output logic [31:0]          ram_wrData,
   input  logic [31:0]          ram_rdData
);

   localparam int AW = ADDR_BITS - 2;

   bridge_state_e       state;
   logic [AW-1:0]       addr_q;
   logic [ID_BITS-1:0]  id_q;
   logic [7:0]          len_q;
   logic [1:0]          burst_q;
   logic [7:0]          beat_cnt;
   logic                issue_done;
   logic                arw_ready_q;
   logic                w_ready_q;
   logic                b_valid_q;

   logic                idle;
   logic                arw_fire;
   logic                w_fire;
   logic                r_fire;
   logic                rd_issue;
   logic                r_room;
   logic                is_last;
   logic [AW-1:0]       cur_addr;
   logic [7:0]          cur_len;
   logic [1:0]          cur_burst;
   logic [7:0]          cur_idx;
   logic [AW-1:0]       next_addr;

   logic                r_valid;
   logic                r_last;
   logic [31:0]         r_data;

   logic                unused_bits;

   assign unused_bits = ^{axi.arw_payload_size, axi.arw_payload_addr[1:0], axi.w_payload_last};

   // In IDLE the first read beat is issued straight from the address payload
   always_comb begin
      idle      = (state == IDLE);
      arw_fire  = axi.arw_valid & arw_ready_q;
      cur_addr  = idle ? axi.arw_payload_addr[ADDR_BITS-1:$clog2(BEAT_BYTES)] : addr_q;
      cur_len   = idle ? axi.arw_payload_len : len_q;
      cur_burst = idle ? axi.arw_payload_burst : burst_q;
      cur_idx   = idle ? 8'd0 : beat_cnt;
      is_last   = (cur_idx == cur_len);
      w_fire    = (state == WRITE) & w_ready_q & axi.w_valid;
      r_fire    = r_valid & axi.r_ready;
      rd_issue  = (idle & arw_fire & ~axi.arw_payload_write)
                | ((state == READ) & ~issue_done & r_room);
   end

   axi_ram_addr_gen #(.AW(AW)) u_addr_gen (
      .addr      (cur_addr),
      .len       (cur_len),
      .burst     (cur_burst),
      .next_addr (next_addr)
   );

   assign ram_en     = rd_issue | w_fire;
   assign ram_wr     = w_fire;
   assign ram_addr   = cur_addr;
   assign ram_mask   = w_fire ? axi.w_payload_strb : 4'hF;
   assign ram_wrData = axi.w_payload_data;

   assign axi.arw_ready      = arw_ready_q;
   assign axi.w_ready        = w_ready_q;
   assign axi.b_valid        = b_valid_q;
   assign axi.b_payload_id   = id_q;
   assign axi.r_valid        = r_valid;
   assign axi.r_payload_data = r_data;
   assign axi.r_payload_id   = id_q;
   assign axi.r_payload_last = r_last;

   // Burst sequencing: address latch, beat counting and the handshake flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         arw_ready_q <= 1'b0;
         w_ready_q   <= 1'b0;
         b_valid_q   <= 1'b0;
         addr_q      <= '0;
         id_q        <= '0;
         len_q       <= '0;
         burst_q     <= '0;
         beat_cnt    <= '0;
         issue_done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               arw_ready_q <= 1'b1;
               if (arw_fire) begin
                  arw_ready_q <= 1'b0;
                  id_q        <= axi.arw_payload_id;
                  len_q       <= axi.arw_payload_len;
                  burst_q     <= axi.arw_payload_burst;
                  if (axi.arw_payload_write) begin
                     state     <= WRITE;
                     w_ready_q <= 1'b1;
                     addr_q    <= cur_addr;
                     beat_cnt  <= '0;
                  end else begin
                     state      <= READ;
                     addr_q     <= next_addr;
                     beat_cnt   <= 8'd1;
                     issue_done <= is_last;
                  end
               end
            end
            READ: begin
               if (rd_issue) begin
                  addr_q     <= next_addr;
                  beat_cnt   <= beat_cnt + 8'd1;
                  issue_done <= is_last;
               end
               if (r_fire && r_last) begin
                  state       <= IDLE;
                  arw_ready_q <= 1'b1;
               end
            end
            WRITE: begin
               if (w_fire) begin
                  addr_q   <= next_addr;
                  beat_cnt <= beat_cnt + 8'd1;
                  if (is_last) begin
                     state     <= WRESP;
                     w_ready_q <= 1'b0;
                     b_valid_q <= 1'b1;
                  end
               end
            end
            WRESP: begin
               if (axi.b_ready) begin
                  b_valid_q   <= 1'b0;
                  state       <= IDLE;
                  arw_ready_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_RAM_BRIDGE_SKID_EN
   logic        pend;
   logic        pend_last;
   logic        capture;
   logic [31:0] buf_data [2];
   logic [1:0]  buf_last;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  occ;

   // The RAM output holds an uncaptured beat until a buffer slot is free, so
   // issue only needs registered occupancy and never looks at r_ready
   assign capture = pend & (occ != 2'd2);
   assign r_room  = ~pend | capture;
   assign r_valid = (occ != 2'd0);
   assign r_data  = buf_data[rd_ptr];
   assign r_last  = buf_last[rd_ptr];

   // Buffer bookkeeping: pending RAM beat, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         pend      <= 1'b0;
         pend_last <= 1'b0;
         buf_last  <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occ       <= '0;
      end else begin
         if (rd_issue) begin
            pend      <= 1'b1;
            pend_last <= is_last;
         end else if (capture) begin
            pend <= 1'b0;
         end
         if (capture) begin
            buf_last[wr_ptr] <= pend_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (r_fire) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + {1'b0, capture} - {1'b0, r_fire};
      end
   end

   // Buffer storage needs no reset; occupancy guards every read
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_data[wr_ptr] <= ram_rdData;
      end
   end
`else
   logic r_valid_q;
   logic r_last_q;

   assign r_room  = ~r_valid_q | axi.r_ready;
   assign r_valid = r_valid_q;
   assign r_last  = r_last_q;
   assign r_data  = ram_rdData;

   // Direct R path: valid follows an issue by one cycle, RAM output is the data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
      end else if (rd_issue) begin
         r_valid_q <= 1'b1;
         r_last_q  <= is_last;
      end else if (r_fire) begin
         r_valid_q <= 1'b0;
      end
   end
`endif

endmodule
